// File: rtl/uniform_rng_pkg.sv
// Shared constants, state encoding and seed helper for the uniform_rng xorshift32 source.
package uniform_rng_pkg;

    localparam logic [31:0] DEFAULT_SEED = 32'h2545_F491;
    localparam int unsigned XS_A         = 13;
    localparam int unsigned XS_B         = 17;
    localparam int unsigned XS_C         = 5;
    localparam int unsigned OUT_WIDTH    = 31;

    typedef enum logic {
        WARMUP,
        RUN
    } rng_state_e;

    // xorshift has a fixed point at zero, so a zero seed is never loaded.
    function automatic logic [31:0] seed_or_default(input logic [31:0] s);
        return (s == '0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/xorshift32_step.sv
// One combinational xorshift32 step (13/17/5), shared by the warm-up and run paths.
module xorshift32_step
    import uniform_rng_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [31:0] a;
    logic [31:0] b;

    always_comb begin
        a = x ^ (x << XS_A);
        b = a ^ (a >> XS_B);
        y = b ^ (b << XS_C);
    end

endmodule

// File: rtl/uniform_rng.sv
// Uniform 31-bit word source: xorshift32 with warm-up, runtime reseed and valid/ready output.
// Optional accepted-sample counter enabled by defining UNIFORM_RNG_COUNT_EN.
module uniform_rng
    import uniform_rng_pkg::*;
#(
    parameter logic [31:0] SEED          = 32'h0000_0001,
    parameter int unsigned WARMUP_CYCLES = 0,
    parameter int unsigned COUNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef UNIFORM_RNG_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] sample_count
`endif
);

    localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES);

    rng_state_e  fsm;
    logic [15:0] warm_cnt;
    logic [31:0] x;
    logic [31:0] x_next;
    logic        xfer;

    xorshift32_step u_step (
        .x (x),
        .y (x_next)
    );

    assign xfer = out_valid && out_ready;
    assign out  = out_valid ? x[31:1] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm       <= WARMUP;
            warm_cnt  <= '0;
            x         <= seed_or_default(SEED);
            out_valid <= 1'b0;
        end else if (seed_load) begin
            fsm       <= WARMUP;
            warm_cnt  <= '0;
            x         <= seed_or_default(seed);
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                WARMUP: begin
                    x <= x_next;
                    // Counter stops at WARM_LAST; the step taken on that cycle is the final one.
                    if (warm_cnt == WARM_LAST) begin
                        fsm       <= RUN;
                        out_valid <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        x <= x_next;
                    end
                end
                default: begin
                    fsm       <= WARMUP;
                    warm_cnt  <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef UNIFORM_RNG_COUNT_EN
    // Counts consumed words, including one accepted on the same cycle as a reseed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sample_count <= '0;
        end else if (xfer) begin
            sample_count <= sample_count + 1'b1;
        end
    end
`else
    logic unused_count_width;
    assign unused_count_width = ^COUNT_WIDTH;
`endif

endmodule

// File: tb/tb_uniform_rng.sv
// Self-checking bench for uniform_rng: scoreboard of golden xorshift32 words plus directed checks.
module tb_uniform_rng;

    localparam logic [31:0] DEF_SEED = 32'h2545_F491;
    localparam int          TB_CW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [31:0] seed;
    logic [30:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] out5;
    logic        out_valid5;
`ifdef UNIFORM_RNG_COUNT_EN
    logic [TB_CW-1:0] sample_count;
    logic [TB_CW-1:0] sample_count5;
`endif

    int tests = 0;
    int fails = 0;
    int model_cnt = 0;
    logic [30:0] q[$];

    always #5 clk = ~clk;

    uniform_rng #(
        .SEED          (32'h0000_0001),
        .WARMUP_CYCLES (0)
`ifdef UNIFORM_RNG_COUNT_EN
        , .COUNT_WIDTH (TB_CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef UNIFORM_RNG_COUNT_EN
        , .sample_count (sample_count)
`endif
    );

    uniform_rng #(
        .SEED          (32'h0000_0001),
        .WARMUP_CYCLES (5)
`ifdef UNIFORM_RNG_COUNT_EN
        , .COUNT_WIDTH (TB_CW)
`endif
    ) dut5 (
        .clk       (clk),
        .rst       (rst),
        .seed_load (1'b0),
        .seed      (32'h0),
        .out       (out5),
        .out_valid (out_valid5),
        .out_ready (1'b1)
`ifdef UNIFORM_RNG_COUNT_EN
        , .sample_count (sample_count5)
`endif
    );

    function automatic logic [31:0] gstep(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected words for a freshly loaded seed with zero warm-up (one step before the first word).
    task automatic push_seq(input logic [31:0] s, input int n);
        logic [31:0] v;
        v = (s == 32'h0) ? DEF_SEED : s;
        v = gstep(v);
        q.delete();
        for (int i = 0; i < n; i++) begin
            q.push_back(v[31:1]);
            v = gstep(v);
        end
    endtask

    task automatic run(input int n, input bit rand_ready, input bit check_nz);
        int done;
        int cyc;
        bit r;
        done = 0;
        cyc = 0;
        while (done < n && cyc < n * 8 + 20) begin
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (q.size() == 0) check("queue_empty", 32'd1, 32'd0);
                else check("word", 32'(out), 32'(q[0]));
                if (check_nz) check("nonzero", 32'(out == '0), 32'd0);
                if (r && q.size() != 0) begin
                    void'(q.pop_front());
                    done++;
                    model_cnt++;
                end
            end
            out_ready = r;
            tick();
            cyc++;
        end
        check("run_done", done, n);
    endtask

    initial begin
        logic [31:0] g6;
        int edge5;

        rst = 1'b0;
        seed_load = 1'b0;
        seed = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid5", 32'(out_valid5), 32'd0);
`ifdef UNIFORM_RNG_COUNT_EN
        check("rst_count", 32'(sample_count), 32'd0);
`endif

        // Release reset with dut stalled while waiting for the warm-up instance.
        push_seq(32'h1, 2000);
        model_cnt = 0;
        rst = 1'b1;
        edge5 = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                check("first_valid", 32'(out_valid), 32'd1);
                check("first_word", 32'(out), 32'h0002_1010);
            end
            if (out_valid) check("stall_word", 32'(out), 32'(q[0]));
            if (out_valid5 && edge5 == 0) begin
                edge5 = i;
                break;
            end
        end
        check("warmup_latency", edge5, 6);
        g6 = 32'h1;
        for (int i = 0; i < 6; i++) g6 = gstep(g6);
        check("warmup_word", 32'(out5), 32'(g6[31:1]));

        run(1000, 1'b0, 1'b0);
        run(150, 1'b1, 1'b0);
`ifdef UNIFORM_RNG_COUNT_EN
        check("count_run", 32'(sample_count), 32'(TB_CW'(model_cnt)));
`endif

        // Reset while running, with ready asserted.
        out_ready = 1'b1;
        rst = 1'b0;
        tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
`ifdef UNIFORM_RNG_COUNT_EN
        check("midrst_count", 32'(sample_count), 32'd0);
`endif
        rst = 1'b1;
        model_cnt = 0;
        push_seq(32'h1, 200);
        run(10, 1'b0, 1'b0);

        // Reseed coinciding with a transfer.
        check("pre_reseed_valid", 32'(out_valid), 32'd1);
        check("pre_reseed_word", 32'(out), 32'(q[0]));
        seed_load = 1'b1;
        seed = 32'h1;
        out_ready = 1'b1;
        model_cnt++;
        tick();
        seed_load = 1'b0;
        check("reseed_valid", 32'(out_valid), 32'd0);
`ifdef UNIFORM_RNG_COUNT_EN
        check("reseed_count", 32'(sample_count), 32'd11);
`endif
        push_seq(32'h1, 200);
        tick();
        check("reseed_first", 32'(out), 32'h0002_1010);
        run(20, 1'b1, 1'b0);

        // Zero seed falls back to the default seed.
        seed_load = 1'b1;
        seed = 32'h0;
        out_ready = 1'b0;
        tick();
        seed_load = 1'b0;
        check("zseed_valid", 32'(out_valid), 32'd0);
        push_seq(32'h0, 300);
        run(100, 1'b1, 1'b1);

        // Counter wrap after a fresh reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_cnt = 0;
        push_seq(32'h1, 100);
        run(17, 1'b0, 1'b0);
`ifdef UNIFORM_RNG_COUNT_EN
        check("count_wrap", 32'(sample_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uniform_rng.md
Name: uniform_rng

Overview:
- Pseudo-random source that produces 31-bit uniform words for the in_ input of the Gaussian inverse-CDF model stage; sits directly upstream of it.
- Core is an xorshift32 generator (shifts 13/17/5) with a warm-up sequencer and runtime reseeding.
- Output uses a valid/ready handshake so the consumer can stall the stream.

Parameters:
- SEED, 32'h0000_0001, seed loaded at reset; a zero value is replaced by DEFAULT_SEED.
- WARMUP_CYCLES, 0, number of extra generator steps discarded after reset or reseed (0..65535).
- COUNT_WIDTH, 32, width of sample_count; used only when UNIFORM_RNG_COUNT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- seed_load  in  1  single-cycle reseed strobe.
- seed  in  32  new seed, sampled when seed_load=1.
- out  out  31  uniform word; drives the in_ input of the Gaussian inverse-CDF model.
- out_valid  out  1  out holds a valid sample.
- out_ready  in  1  consumer accepts the sample this cycle.
- sample_count  out  COUNT_WIDTH  number of accepted samples; present only with UNIFORM_RNG_COUNT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low; it is sampled on the clk rising edge.
- rst=0 at an edge sets:
  - FSM=WARMUP, warm-up counter=0;
  - state=SEED, or DEFAULT_SEED (32'h2545_F491) if SEED==0;
  - out_valid=0, out=0, sample_count=0.
- Step function: x^=x<<13; x^=x>>17; x^=x<<5, all 32-bit with truncation. The state is never zero.
- FSM states: WARMUP, RUN.
- WARMUP:
  - Applies one step per cycle and increments the counter.
  - After exactly WARMUP_CYCLES+1 steps it moves to RUN; at least one step is always taken.
  - out_valid=0 throughout.
- RUN:
  - out_valid=1; out=state[31:1], taken directly from the state register.
  - On out_valid&&out_ready (a transfer), state<=step(state), so the next word is available the following cycle. This gives one word per cycle under continuous ready.
- Latency: the first out_valid=1 appears WARMUP_CYCLES+1 edges after the first edge with rst=1.
- Stall: while out_valid&&!out_ready, out and state hold stable. out_valid never deasserts except on reseed or reset.
- Reseed (seed_load=1 in any state):
  - state<=seed, or DEFAULT_SEED if seed==0;
  - counter<=0, FSM<=WARMUP;
  - out_valid=0 from the next cycle.
- Simultaneous events:
  - If seed_load coincides with a transfer, the presented word counts as consumed (sample_count increments), and the reseed overrides the step.
  - rst=0 has priority over seed_load.
- Warm-up counter is 16 bits and saturates only at WARMUP_CYCLES; it never wraps.

Optional Feature:
- Macro UNIFORM_RNG_COUNT_EN.
- Defined:
  - sample_count port exists.
  - Increments by 1 on each transfer and wraps modulo 2^COUNT_WIDTH.
  - Cleared by reset only, not by seed_load.
- Undefined: the port and counter are absent, and the handshake is otherwise unchanged.

Decomposition:
- Package uniform_rng_pkg holds:
  - DEFAULT_SEED and shift constants XS_A=13, XS_B=17, XS_C=5;
  - state-enum typedef (WARMUP, RUN);
  - OUT_WIDTH=31.
- One combinational sub-module, xorshift32_step (32-bit in, 32-bit out), shared by the WARMUP and RUN paths.

Test Plan:
- Seed and first words: SEED=1, WARMUP_CYCLES=0, out_ready=1 → first valid out=0x21010 (state 0x42021) one edge after reset release. The next words match the golden xorshift32 model >>1 for 1000 samples.
- Backpressure: out_ready toggled pseudo-randomly → out is stable while stalled. The accepted sequence is identical to the free-running sequence, with no gaps or duplicates.
- Mid-run reseed: after 10 transfers, seed_load=1 with seed=1 and out_ready=1 → out_valid=0 next cycle, then out=0x21010 again. sample_count=11.
- Zero seed: seed_load with seed=0 → state=0x2545F491. Outputs match the golden model from that seed and are never all-zero.
- Warm-up and reset: WARMUP_CYCLES=5 → out_valid rises 6 edges after reset release, first out=step^6(SEED)>>1. Asserting rst=0 mid-RUN gives out_valid=0 and sample_count=0 at the next edge.
- Counter wrap: with UNIFORM_RNG_COUNT_EN, COUNT_WIDTH=4, 17 transfers → sample_count=1.
